// File: rtl/vco_spi_master.sv
// SPI initiator for the front-end VCO/PLL synthesizer: host words are queued in a FIFO,
// shifted out MSB-first on vco_sclk/vco_sdata, and latched with a vco_le pulse.
module vco_spi_master #(
  parameter logic [6:0]  ADDR   = 7'd96,
  parameter int unsigned CLKDIV = 4,
  parameter int unsigned DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        serial_strobe,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  output logic        vco_sclk,
  output logic        vco_sdata,
  output logic        vco_le,
  input  logic        vco_muxout,
  output logic        busy,
  output logic [31:0] status
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [6:0]    CTRL_ADDR = ADDR + 7'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_LE_SETUP, S_LE_PULSE, S_GAP
  } state_t;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_n;
  logic          r_ovf, r_mux_meta, r_mux_sync;
  state_t        r_state, w_state_n;
  logic [31:0]   r_shreg, w_shreg_n;
  logic [4:0]    r_bitcnt, w_bitcnt_n;
  logic [DW-1:0] r_divcnt, w_divcnt_n;
  logic          r_phase, w_phase_n;
  logic          r_sclk, r_sdata, r_le, r_busy;
  logic          w_push_req, w_full, w_pop, w_push, w_ovf_set, w_ovf_clr, w_div_done;

  assign w_push_req = serial_strobe && (serial_addr == ADDR);
  assign w_ovf_clr  = serial_strobe && (serial_addr == CTRL_ADDR) && serial_data[0];
  assign w_full     = (r_count == FULL);
  assign w_pop      = (r_state == S_LOAD);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_count_n  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_div_done = (r_divcnt == DIV_LAST);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= serial_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_mux_meta <= 1'b0;
      r_mux_sync <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_n;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      r_mux_meta <= vco_muxout;
      r_mux_sync <= r_mux_meta;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_shreg_n  = r_shreg;
    w_bitcnt_n = r_bitcnt;
    w_divcnt_n = r_divcnt;
    w_phase_n  = r_phase;
    case (r_state)
      S_IDLE: if (r_count != '0) w_state_n = S_LOAD;
      S_LOAD: begin
        w_shreg_n  = r_mem[r_rd_ptr];
        w_bitcnt_n = 5'd31;
        w_divcnt_n = '0;
        w_phase_n  = 1'b0;
        w_state_n  = S_SHIFT;
      end
      S_SHIFT: begin
        if (!w_div_done) begin
          w_divcnt_n = r_divcnt + 1'b1;
        end else begin
          w_divcnt_n = '0;
          if (!r_phase) begin
            w_phase_n = 1'b1;
          end else begin
            w_phase_n = 1'b0;
            if (r_bitcnt == 5'd0) begin
              w_state_n = S_LE_SETUP;
            end else begin
              w_shreg_n  = {r_shreg[30:0], 1'b0};
              w_bitcnt_n = r_bitcnt - 5'd1;
            end
          end
        end
      end
      S_LE_SETUP, S_LE_PULSE, S_GAP: begin
        if (!w_div_done) begin
          w_divcnt_n = r_divcnt + 1'b1;
        end else begin
          w_divcnt_n = '0;
          case (r_state)
            S_LE_SETUP: w_state_n = S_LE_PULSE;
            S_LE_PULSE: w_state_n = S_GAP;
            default:    w_state_n = S_IDLE;
          endcase
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Pins are registered from next-state values so they line up with the state they belong to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_divcnt <= '0;
      r_phase  <= 1'b0;
      r_sclk   <= 1'b0;
      r_sdata  <= 1'b0;
      r_le     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_shreg  <= w_shreg_n;
      r_bitcnt <= w_bitcnt_n;
      r_divcnt <= w_divcnt_n;
      r_phase  <= w_phase_n;
      r_sclk   <= (w_state_n == S_SHIFT) && w_phase_n;
      r_sdata  <= (w_state_n == S_SHIFT) && w_shreg_n[31];
      r_le     <= (w_state_n == S_LE_PULSE);
      r_busy   <= (w_state_n != S_IDLE) || (w_count_n != '0);
    end
  end

  assign vco_sclk  = r_sclk;
  assign vco_sdata = r_sdata;
  assign vco_le    = r_le;
  assign busy      = r_busy;
  assign status    = {16'd0, 8'(r_count), 5'd0, r_ovf, r_busy, r_mux_sync};

endmodule

// File: tb/tb_vco_spi_master.sv
// Scoreboard bench for vco_spi_master: stimulus pushes expected SPI words, a pin monitor
// reassembles each word at its LE pulse and checks it against the queue.
module tb_vco_spi_master;
  localparam int unsigned CLKDIV = 4;
  localparam logic [6:0]  ADDR   = 7'd96;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe = 1'b0;
  logic [6:0]  addr = '0;
  logic [31:0] data = '0;
  logic        muxout = 1'b0;
  logic        sclk, sdata, le, busy;
  logic [31:0] status;

  always #5 clock = ~clock;

  vco_spi_master #(.ADDR(ADDR), .CLKDIV(CLKDIV), .DEPTH(8)) dut (
    .clock(clock), .reset(rst_n), .serial_strobe(strobe), .serial_addr(addr),
    .serial_data(data), .vco_sclk(sclk), .vco_sdata(sdata), .vco_le(le),
    .vco_muxout(muxout), .busy(busy), .status(status)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  int          le_times[$];
  int          cyc = 0;
  logic        p_sclk = 1'b0, p_sdata = 1'b0, p_le = 1'b0;
  int          mon_bits = 0;
  logic [31:0] mon_word = '0;
  int          le_w = 0;
  int          setup_viol = 0;

  always @(negedge clock) begin
    cyc++;
    if (!rst_n) begin
      mon_bits = 0; mon_word = '0; le_w = 0; setup_viol = 0;
      p_sclk = 1'b0; p_sdata = 1'b0; p_le = 1'b0;
    end else begin
      if (sclk && !p_sclk) begin
        mon_word = {mon_word[30:0], sdata};
        mon_bits++;
      end
      if (sclk && p_sclk && (sdata !== p_sdata)) setup_viol++;
      if (le && !p_le) begin
        le_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL le_unexpected: got word %h expected no LE", mon_word);
        end else begin
          check("spi_word", mon_word, exp_q.pop_front());
        end
        check("sclk_edges", mon_bits, 32);
        check("sdata_stable_sclk_high", setup_viol, 0);
        mon_bits = 0;
        setup_viol = 0;
      end
      if (le) le_w++;
      else if (p_le) begin
        check("le_width", le_w, CLKDIV);
        le_w = 0;
      end
      p_sclk = sclk; p_sdata = sdata; p_le = le;
    end
  end

  task automatic write(input logic [6:0] a, input logic [31:0] d);
    strobe = 1'b1; addr = a; data = d;
    @(negedge clock);
    strobe = 1'b0; addr = '0; data = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy === 1'b1 && n < max) begin
      @(negedge clock);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  logic [31:0] adf [6] = '{32'h0058_0005, 32'h0085_003C, 32'h0000_04B3,
                           32'h1800_4E42, 32'h0800_8011, 32'h0000_0000};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    #23;
    check("rst_sclk", sclk, 1'b0);
    check("rst_sdata", sdata, 1'b0);
    check("rst_le", le, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_status", status, 32'h0);
    @(negedge clock);
    rst_n = 1'b1;
    cycles(2);

    // single word, busy duration
    exp_q.push_back(32'hA5A5_0001);
    write(ADDR, 32'hA5A5_0001);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clock);
    end
    check("busy_cycles", n, 270);
    check("t1_drained", exp_q.size(), 0);

    // six back-to-back ADF4350 words
    le_times.delete();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(adf[i]);
      write(ADDR, adf[i]);
    end
    check("t2_ovf_after_writes", status[2], 1'b0);
    wait_idle("t2_drain", 3000);
    check("t2_le_count", le_times.size(), 6);
    for (int i = 1; i < le_times.size(); i++)
      check("b2b_le_spacing", le_times[i] - le_times[i-1], 270);
    check("t2_drained", exp_q.size(), 0);
    check("t2_ovf", status[2], 1'b0);

    // overflow with the FSM stalled in a word; push+pop at full
    cycles(1);
    exp_q.push_back(32'h1111_0000);
    write(ADDR, 32'h1111_0000);
    cycles(4);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(32'h3000_0000 + i);
      write(ADDR, 32'h3000_0000 + i);
    end
    check("full_count", status[15:8], 8'd8);
    check("ovf_set", status[2], 1'b1);
    check("full_busy", status[1], 1'b1);
    write(ADDR + 7'd1, 32'h1);
    check("ovf_clear", status[2], 1'b0);
    check("count_after_clear", status[15:8], 8'd8);
    cycles(257);
    exp_q.push_back(32'h7777_AAAA);
    write(ADDR, 32'h7777_AAAA);
    check("push_pop_full_count", status[15:8], 8'd8);
    check("push_pop_full_ovf", status[2], 1'b0);
    wait_idle("t3_drain", 4000);
    check("t3_drained", exp_q.size(), 0);

    // reset in the middle of bit 15
    cycles(1);
    exp_q.push_back(32'h1234_5678);
    write(ADDR, 32'h1234_5678);
    n = 0;
    while (mon_bits != 17 && n < 1000) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("reach_bit15", mon_bits, 17);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_sdata", sdata, 1'b0);
    check("midrst_le", le, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_status", status, 32'h0);
    exp_q.delete();
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    check("post_rst_status", status, 32'h0);
    exp_q.push_back(32'hC3C3_5A5A);
    write(ADDR, 32'hC3C3_5A5A);
    wait_idle("t4_drain", 1000);
    check("t4_drained", exp_q.size(), 0);

    // muxout synchronizer latency and ignored address
    muxout = 1'b1;
    @(negedge clock);
    check("muxout_1clk", status[0], 1'b0);
    @(negedge clock);
    check("muxout_2clk", status[0], 1'b1);
    write(ADDR + 7'd2, 32'hFFFF_FFFF);
    cycles(3);
    check("other_addr_status", status, 32'h1);
    check("other_addr_busy", busy, 1'b0);
    cycles(300);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
